// File: rtl/disp_scan_ctrl_if.sv
// Load handshake between a value producer and disp_scan_ctrl.
//   load_valid : producer offers load_data this cycle
//   load_data  : four hex nibbles, [3:0] = rightmost digit, [15:12] = leftmost
//   load_ready : controller can take a new value this cycle
// master = producer side, slave = disp_scan_ctrl side.
interface disp_scan_ctrl_if;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered load.
// Each digit is lit for CLK_DIV clk cycles, digits 0..3 in turn. A new value is
// captured into a pending buffer and only copied into the displayed register at
// a frame boundary, so a frame never shows a mix of old and new digits.
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   enable        : 1 = scan, 0 = display dark
//   blank_lz      : 1 = suppress leading zeros (digit 0 is always shown)
//   load          : load handshake (slave side)
//   digit_an      : active-low anode enables, bit i = digit i
//   nibble        : hex value of the current digit
//   nibble_blank  : current digit suppressed as a leading zero
//   frame_done    : one-cycle pulse as digit 0 is shown again after digit 3
module disp_scan_ctrl #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             blank_lz,
  disp_scan_ctrl_if.slave  load,
  output logic [3:0]       digit_an,
  output logic [3:0]       nibble,
  output logic             nibble_blank,
  output logic             frame_done
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e         state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]     idx_q, idx_d;
  logic [15:0]    active_q, active_d;
  logic [15:0]    pending_q, pending_d;
  logic           pend_q, pend_d;
  logic [3:0]     an_d;
  logic [3:0]     nib_d;
  logic           blank_d;
  logic           frame_d;
  logic           slot_end;
  logic [3:0]     lz_mask;

  assign load.load_ready = ~pend_q;
  assign slot_end        = (div_q == DivMax);

  // Next-state: scan counters, buffer transfer, load acceptance.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    idx_d     = idx_q;
    active_d  = active_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    frame_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        div_d = '0;
        idx_d = 2'd0;
        if (pend_q) begin
          active_d = pending_q;
          pend_d   = 1'b0;
        end
        if (enable) state_d = StScan;
      end
      StScan: begin
        if (!enable) begin
          state_d = StIdle;
          div_d   = '0;
          idx_d   = 2'd0;
        end else if (slot_end) begin
          div_d   = '0;
          idx_d   = idx_q + 2'd1;
          frame_d = (idx_q == 2'd3);
        end else begin
          div_d = div_q + DivW'(1);
        end
        // Swap buffers only at the digit-3 slot end so frames never mix values.
        if (slot_end && (idx_q == 2'd3) && pend_q) begin
          active_d = pending_q;
          pend_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // load_ready is ~pend_q, so acceptance never collides with a transfer.
    if (load.load_valid && !pend_q) begin
      pending_d = load.load_data;
      pend_d    = 1'b1;
    end
  end

  // Leading-zero mask: digit i is a leading zero when nibbles i..3 are all zero.
  always_comb begin
    lz_mask    = 4'b0000;
    lz_mask[1] = (active_d[15:4] == 12'h000);
    lz_mask[2] = (active_d[15:8] == 8'h00);
    lz_mask[3] = (active_d[15:12] == 4'h0);
  end

  // Outputs are registered from next-state values so they line up with the
  // counters: the first SCAN cycle already shows digit 0.
  always_comb begin
    an_d    = 4'b1111;
    nib_d   = 4'h0;
    blank_d = 1'b0;
    if (state_d == StScan) begin
      nib_d = active_d[{idx_d, 2'b00} +: 4];
      if (blank_lz && lz_mask[idx_d]) begin
        blank_d = 1'b1;
      end else begin
        an_d[idx_d] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      div_q        <= '0;
      idx_q        <= 2'd0;
      active_q     <= 16'h0000;
      pending_q    <= 16'h0000;
      pend_q       <= 1'b0;
      digit_an     <= 4'b1111;
      nibble       <= 4'h0;
      nibble_blank <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_q       <= pend_d;
      digit_an     <= an_d;
      nibble       <= nib_d;
      nibble_blank <= blank_d;
      frame_done   <= frame_d;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl (CLK_DIV = 4). A reference model tracks
// the scan as "cycles since scan start" and derives the digit from that count;
// each cycle's expected outputs are queued and a negedge monitor compares them.
module tb_disp_scan_ctrl;

  localparam int unsigned D = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] nib;
    logic       blank;
    logic       frame;
    logic       ready;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       blank_lz;
  logic [3:0] digit_an;
  logic [3:0] nibble;
  logic       nibble_blank;
  logic       frame_done;

  disp_scan_ctrl_if bus ();

  disp_scan_ctrl #(.CLK_DIV(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .blank_lz     (blank_lz),
    .load         (bus),
    .digit_an     (digit_an),
    .nibble       (nibble),
    .nibble_blank (nibble_blank),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model state.
  bit          m_scan;
  int unsigned m_t;
  logic [15:0] m_act;
  logic [15:0] m_pbuf;
  bit          m_pend;

  task automatic model(input logic r, input logic en, input logic bl,
                       input logic v, input logic [15:0] d);
    exp_t        e;
    bit          acc;
    bit          fe;
    bit          frame_end;
    int unsigned idx;
    logic [15:0] upper;
    fe = 1'b0;
    if (r) begin
      m_scan = 1'b0; m_t = 0; m_act = '0; m_pbuf = '0; m_pend = 1'b0;
    end else begin
      acc = v && !m_pend;
      if (!m_scan) begin
        if (m_pend) begin m_act = m_pbuf; m_pend = 1'b0; end
        if (en) begin m_scan = 1'b1; m_t = 0; end
      end else begin
        frame_end = (m_t % (4 * D)) == (4 * D - 1);
        if (frame_end && m_pend) begin m_act = m_pbuf; m_pend = 1'b0; end
        if (en) begin m_t = m_t + 1; fe = frame_end; end
        else m_scan = 1'b0;
      end
      if (acc) begin m_pbuf = d; m_pend = 1'b1; end
    end
    e.an = 4'b1111; e.nib = 4'h0; e.blank = 1'b0;
    if (m_scan) begin
      idx   = (m_t / D) % 4;
      upper = m_act >> (4 * idx);
      e.nib = upper[3:0];
      if (bl && idx != 0 && upper == 16'h0) e.blank = 1'b1;
      else e.an = ~(4'b0001 << idx);
    end
    e.frame = fe;
    e.ready = !m_pend;
    sb.push_back(e);
  endtask

  task automatic step();
    logic r, en, bl, v;
    logic [15:0] d;
    r = rst; en = enable; bl = blank_lz; v = bus.load_valid; d = bus.load_data;
    @(posedge clk);
    model(r, en, bl, v, d);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_once(input logic [15:0] val);
    bus.load_valid = 1'b1;
    bus.load_data  = val;
    step();
    bus.load_valid = 1'b0;
  endtask

  function automatic logic [15:0] rnd_val();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    return v;
  endfunction

  exp_t mon_e;
  exp_t mon_g;
  always @(negedge clk) begin
    cyc++;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_g = '{an: digit_an, nib: nibble, blank: nibble_blank, frame: frame_done,
                ready: bus.load_ready};
      n_checks++;
      if (mon_g !== mon_e) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d: got an=%b nib=%h blank=%b frame=%b ready=%b, want an=%b nib=%h blank=%b frame=%b ready=%b",
                 cyc, mon_g.an, mon_g.nib, mon_g.blank, mon_g.frame, mon_g.ready,
                 mon_e.an, mon_e.nib, mon_e.blank, mon_e.frame, mon_e.ready);
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; blank_lz = 1'b0;
    bus.load_valid = 1'b0; bus.load_data = 16'h0;
    run(2);
    rst = 1'b0;
    run(2);

    // Load in IDLE, then scan one value over several frames.
    load_once(16'h1234);
    run(2);
    enable = 1'b1;
    run(36);

    // Load during digit 1; must not appear until the frame boundary.
    while (((m_t / D) % 4) != 1) step();
    load_once(16'hABCD);
    run(40);

    // Leading-zero suppression.
    blank_lz = 1'b1;
    load_once(16'h0070);
    run(40);
    load_once(16'h0000);
    run(40);
    blank_lz = 1'b0;
    run(20);

    // Drop enable mid digit 2, then re-enable.
    while (((m_t / D) % 4) != 2 || (m_t % D) != 1) step();
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    run(20);

    // Reset with a pending value and load_valid high.
    load_once(16'h5A5A);
    bus.load_valid = 1'b1; bus.load_data = 16'h9999;
    rst = 1'b1;
    step();
    rst = 1'b0; bus.load_valid = 1'b0;
    run(20);

    // load_valid held high: one acceptance per frame.
    bus.load_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      bus.load_data = rnd_val();
      step();
    end
    bus.load_valid = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      bus.load_valid = ($urandom_range(0, 4) == 0);
      bus.load_data  = rnd_val();
      step();
    end
    rst = 1'b0; bus.load_valid = 1'b0;
    run(4);

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
